latch_flop_divergence_monitor: RTL and testbench
================================================

# latch_flop_divergence_monitor

Multi-channel, parametrised successor to the single-bit latch/flop comparison block. Each channel holds a flop-based register and derives a latch-free transparent-equivalent view of the same enable/data pair. The block counts cycles where the two views diverge and raises a per-channel alarm when divergence persists for a configurable run length. It sits beside datapath registers as a lint-by-simulation and silicon debug monitor.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- CHANNELS, 4, number of independent channels (≥1)
- CNT_W, 8, width of each per-channel divergence counter (≥2)
- THRESH, 3, consecutive divergent cycles that trigger alarm (1..255)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  CHANNELS  per-channel capture enable
- d  input  CHANNELS*WIDTH  per-channel data, channel i at [i*WIDTH +: WIDTH]
- clr  input  1  synchronous clear of counters, run counters, alarms (not q_flop)
- q_flop  output  CHANNELS*WIDTH  edge-captured register per channel
- q_xpar  output  CHANNELS*WIDTH  transparent-equivalent view: en[i] ? d[i] : q_flop[i] (combinational mux, no latch)
- div_cnt  output  CHANNELS*CNT_W  saturating divergent-cycle count per channel
- alarm  output  CHANNELS  per-channel sticky alarm
- any_alarm  output  1  OR of alarm
- irq  output  1  one-cycle pulse, see Configuration

## Operation
- q_flop[i] <= d[i] on rising edge when en[i]=1; holds otherwise.
- mismatch[i] = (q_xpar[i] != q_flop[i]), evaluated combinationally; true only when en[i]=1 and d[i]≠q_flop[i].
- div_cnt[i] increments on each edge where mismatch[i]=1; saturates at 2^CNT_W−1, never wraps.
- Per-channel FSM, states MATCH, DIVERGE, ALARM; run counter run[i], width $clog2(THRESH+1).
  - MATCH: mismatch → run=1; go ALARM if THRESH=1, else DIVERGE. No mismatch → stay, run=0.
  - DIVERGE: mismatch → run+1; go ALARM when run+1 = THRESH. No mismatch → MATCH, run=0.
  - ALARM: sticky; exits only on clr or rst. div_cnt keeps counting.
- alarm[i] = (state[i]==ALARM), registered.
- clr=1: next state MATCH, run=0, div_cnt=0 for all channels; clr wins over a same-cycle mismatch (that cycle is not counted). q_flop unaffected.
- Channels fully independent; simultaneous alarms on several channels are legal.

## Timing
- Reset values: q_flop=0, div_cnt=0, alarm=0, any_alarm=0, irq=0, all FSMs MATCH, run=0.
- rst asserted mid-operation clears everything immediately (asynchronous), regardless of clk.
- q_xpar: zero latency from en/d. q_flop: one cycle.
- Mismatch in cycle N is visible in div_cnt, FSM state and alarm after edge N (cycle N+1).
- Alarm latency: THRESH consecutive mismatch cycles N..N+THRESH−1 → alarm high from cycle N+THRESH.
- A single matching cycle inside a run resets run to 0; runs never accumulate across gaps.
- any_alarm is combinational OR of registered alarm bits (same cycle as alarm).

## Configuration
- LFDM_IRQ_EN defined: irq is a registered one-cycle pulse in the cycle after any channel transitions DIVERGE/MATCH→ALARM (i.e., cycle alarm rises +1); multiple channels rising together yield one pulse; no pulse while already in ALARM.
- LFDM_IRQ_EN undefined: irq tied to 0; no irq register.

## Test plan
- Reset: assert rst mid-stream with div_cnt[0]=5, alarm[0]=1 → all outputs 0 immediately, before next edge.
- Transparency: ch0 q_flop=0x00, en=1, d=0xA5 → q_xpar=0xA5 same cycle, q_flop=0xA5 next cycle, div_cnt[0]=1.
- Threshold: THRESH=3, ch1 d changes every cycle with en=1 for 3 cycles (0x01,0x02,0x03) → alarm[1]=1 after third edge, any_alarm=1; with LFDM_IRQ_EN irq pulses once the following cycle.
- Run break: ch2 mismatch, mismatch, match (en=0), mismatch → alarm[2] stays 0, div_cnt[2]=3.
- Saturation: CNT_W=2, 5 consecutive mismatches on ch3 → div_cnt[3]=3, stays 3.
- Clear priority: clr=1 in same cycle as mismatch on ch0 with alarm[0]=1 → next cycle div_cnt[0]=0, alarm[0]=0, q_flop[0] updated to d.

Source files
------------

// File: rtl/latch_flop_divergence_monitor.sv
// latch_flop_divergence_monitor
// Multi-channel monitor comparing a flop-captured register against its
// latch-free transparent-equivalent view (en ? d : q_flop). Counts divergent
// cycles per channel (saturating) and raises a sticky per-channel alarm when
// divergence persists for THRESH consecutive cycles.
// Optional feature macro: LFDM_IRQ_EN -- when defined, irq is a registered
// one-cycle pulse the cycle after any alarm rises; otherwise irq is tied to 0.
module latch_flop_divergence_monitor #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int THRESH   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          en,
    input  logic [CHANNELS*WIDTH-1:0]    d,
    input  logic                         clr,
    output logic [CHANNELS*WIDTH-1:0]    q_flop,
    output logic [CHANNELS*WIDTH-1:0]    q_xpar,
    output logic [CHANNELS*CNT_W-1:0]    div_cnt,
    output logic [CHANNELS-1:0]          alarm,
    output logic                         any_alarm,
    output logic                         irq
);

    localparam int RUN_W = $clog2(THRESH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [RUN_W-1:0] THRESH_R = RUN_W'(THRESH);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

    typedef enum logic [1:0] {
        ST_MATCH   = 2'd0,
        ST_DIVERGE = 2'd1,
        ST_ALARM   = 2'd2
    } state_t;

    logic [WIDTH-1:0] q_flop_q [CHANNELS];
    logic [WIDTH-1:0] q_flop_d [CHANNELS];
    state_t           state_q  [CHANNELS];
    state_t           state_d  [CHANNELS];
    logic [RUN_W-1:0] run_q    [CHANNELS];
    logic [RUN_W-1:0] run_d    [CHANNELS];
    logic [CNT_W-1:0] cnt_q    [CHANNELS];
    logic [CNT_W-1:0] cnt_d    [CHANNELS];
    logic [CHANNELS-1:0] mismatch;
    logic [CHANNELS-1:0] entering;

    // Transparent view, mismatch detect and next register value per channel.
    // NOTE: every variable gets a default at the top of always_comb so that no
    // path leaves it unassigned; an unassigned path would infer a latch.
    always_comb begin
        q_xpar   = '0;
        q_flop   = '0;
        mismatch = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            q_flop_d[i] = q_flop_q[i];
            if (en[i]) begin
                q_flop_d[i] = d[i*WIDTH +: WIDTH];
            end
            // The transparent view is a plain mux in front of the flop output,
            // giving latch-like zero-latency behaviour without a storage latch.
            q_xpar[i*WIDTH +: WIDTH] = en[i] ? d[i*WIDTH +: WIDTH] : q_flop_q[i];
            q_flop[i*WIDTH +: WIDTH] = q_flop_q[i];
            mismatch[i] = en[i] && (d[i*WIDTH +: WIDTH] != q_flop_q[i]);
        end
    end

    // Next-state logic for the per-channel run FSM and saturating counter.
    always_comb begin
        entering = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            run_d[i]   = run_q[i];
            cnt_d[i]   = cnt_q[i];
            if (clr) begin
                // Clear dominates a same-cycle mismatch: nothing is counted.
                state_d[i] = ST_MATCH;
                run_d[i]   = '0;
                cnt_d[i]   = '0;
            end else begin
                if (mismatch[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
                case (state_q[i])
                    ST_MATCH: begin
                        if (mismatch[i]) begin
                            run_d[i] = RUN_ONE;
                            if (THRESH == 1) begin
                                state_d[i]  = ST_ALARM;
                                entering[i] = 1'b1;
                            end else begin
                                state_d[i] = ST_DIVERGE;
                            end
                        end else begin
                            run_d[i] = '0;
                        end
                    end
                    ST_DIVERGE: begin
                        if (mismatch[i]) begin
                            run_d[i] = run_q[i] + RUN_ONE;
                            if ((run_q[i] + RUN_ONE) == THRESH_R) begin
                                state_d[i]  = ST_ALARM;
                                entering[i] = 1'b1;
                            end
                        end else begin
                            state_d[i] = ST_MATCH;
                            run_d[i]   = '0;
                        end
                    end
                    ST_ALARM: begin
                        // Sticky until clr or rst.
                        state_d[i] = ST_ALARM;
                    end
                    default: begin
                        state_d[i] = ST_MATCH;
                        run_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Edge-captured data register per channel; clr deliberately leaves it alone.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                q_flop_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                q_flop_q[i] <= q_flop_d[i];
            end
        end
    end

    // Per-channel FSM state, run length and divergence count.
    // NOTE: these arrays are ordinary per-channel flops, not a RAM, so each
    // element is reset; a true memory array would normally be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_MATCH;
                run_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                run_q[i]   <= run_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Output decode from registered state.
    always_comb begin
        alarm   = '0;
        div_cnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            alarm[i] = (state_q[i] == ST_ALARM);
            div_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign any_alarm = |alarm;

`ifdef LFDM_IRQ_EN
    logic rise_q, rise_d;
    logic irq_q, irq_d;

    // Two-stage pipeline: rise_q is high the cycle alarm rises, irq_q the next.
    always_comb begin
        rise_d = |entering;
        irq_d  = rise_q;
    end

    // Interrupt pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            rise_q <= rise_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_entering;
    assign unused_entering = ^entering;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_latch_flop_divergence_monitor.sv
// Self-checking bench for latch_flop_divergence_monitor (default parameters).
// A behavioural model predicts post-edge outputs; expectations are queued when
// stimulus is driven and popped/compared after the clock edge.
module tb_latch_flop_divergence_monitor;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int CW = 8;
    localparam int TH = 3;

    logic              clk;
    logic              rst;
    logic [CH-1:0]     en;
    logic [CH*W-1:0]   d;
    logic              clr;
    logic [CH*W-1:0]   q_flop;
    logic [CH*W-1:0]   q_xpar;
    logic [CH*CW-1:0]  div_cnt;
    logic [CH-1:0]     alarm;
    logic              any_alarm;
    logic              irq;

    latch_flop_divergence_monitor #(
        .WIDTH(W), .CHANNELS(CH), .CNT_W(CW), .THRESH(TH)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .d(d), .clr(clr),
        .q_flop(q_flop), .q_xpar(q_xpar), .div_cnt(div_cnt),
        .alarm(alarm), .any_alarm(any_alarm), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [CH*W-1:0]  q_flop;
        logic [CH*CW-1:0] div_cnt;
        logic [CH-1:0]    alarm;
        logic             any_alarm;
        logic             irq;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [7:0] m_q   [CH];
    int         m_cnt [CH];
    int         m_st  [CH];   // 0 MATCH, 1 DIVERGE, 2 ALARM
    int         m_run [CH];
    bit         m_rise;
    bit         m_irq;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_q[i] = '0; m_cnt[i] = 0; m_st[i] = 0; m_run[i] = 0;
        end
        m_rise = 1'b0;
        m_irq  = 1'b0;
    endtask

    // Drive one cycle of stimulus, check the zero-latency view, predict and
    // queue the post-edge outputs, then compare them after the edge.
    task automatic step(input string tag, input logic [CH-1:0] e,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3,
                        input logic c);
        logic [7:0]      dv [CH];
        logic [CH*W-1:0] xp;
        bit              mism, ent_any;
        exp_t            ex, got;
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        @(negedge clk);
        en  = e;
        d   = {d3, d2, d1, d0};
        clr = c;
        #1;
        xp = '0;
        for (int i = 0; i < CH; i++) xp[i*W +: W] = e[i] ? dv[i] : m_q[i];
        check({tag, "_q_xpar"}, 64'(q_xpar), 64'(xp));

        ent_any = 1'b0;
        for (int i = 0; i < CH; i++) begin
            mism = e[i] && (dv[i] != m_q[i]);
            if (c) begin
                m_st[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
            end else begin
                if (mism && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
                if (m_st[i] == 0) begin
                    if (mism) begin
                        m_run[i] = 1;
                        if (TH == 1) begin m_st[i] = 2; ent_any = 1'b1; end
                        else m_st[i] = 1;
                    end else m_run[i] = 0;
                end else if (m_st[i] == 1) begin
                    if (mism) begin
                        m_run[i]++;
                        if (m_run[i] == TH) begin m_st[i] = 2; ent_any = 1'b1; end
                    end else begin
                        m_st[i] = 0; m_run[i] = 0;
                    end
                end
            end
            if (e[i]) m_q[i] = dv[i];
        end
`ifdef LFDM_IRQ_EN
        m_irq  = m_rise;
        m_rise = ent_any;
`else
        m_irq  = 1'b0;
`endif
        ex.tag = tag;
        ex.alarm = '0;
        for (int i = 0; i < CH; i++) begin
            ex.q_flop[i*W +: W]    = m_q[i];
            ex.div_cnt[i*CW +: CW] = m_cnt[i][CW-1:0];
            ex.alarm[i]            = (m_st[i] == 2);
        end
        ex.any_alarm = |ex.alarm;
        ex.irq       = m_irq;
        sb.push_back(ex);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.tag, "_q_flop"},    64'(q_flop),    64'(got.q_flop));
        check({got.tag, "_div_cnt"},   64'(div_cnt),   64'(got.div_cnt));
        check({got.tag, "_alarm"},     64'(alarm),     64'(got.alarm));
        check({got.tag, "_any_alarm"}, 64'(any_alarm), 64'(got.any_alarm));
        check({got.tag, "_irq"},       64'(irq),       64'(got.irq));
    endtask

    initial begin
        rst = 1'b1; en = '0; d = '0; clr = 1'b0;
        model_reset();
        #3;
        check("rst_q_flop",  64'(q_flop),    64'h0);
        check("rst_div_cnt", 64'(div_cnt),   64'h0);
        check("rst_alarm",   64'(alarm),     64'h0);
        check("rst_any",     64'(any_alarm), 64'h0);
        check("rst_irq",     64'(irq),       64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Transparency on channel 0
        step("xpar", 4'b0001, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0);
        check("xpar_q_flop0", 64'(q_flop[7:0]),  64'hA5);
        check("xpar_cnt0",    64'(div_cnt[7:0]), 64'd1);

        // Threshold on channel 1: three consecutive mismatches
        step("th1", 4'b0010, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0);
        step("th2", 4'b0010, 8'h00, 8'h02, 8'h00, 8'h00, 1'b0);
        check("th_pre_alarm1", 64'(alarm[1]), 64'd0);
        step("th3", 4'b0010, 8'h00, 8'h03, 8'h00, 8'h00, 1'b0);
        check("th_alarm1", 64'(alarm[1]),  64'd1);
        check("th_any",    64'(any_alarm), 64'd1);
        step("th_idle1", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        step("th_idle2", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

        // Run break on channel 2
        step("rb1", 4'b0100, 8'h00, 8'h00, 8'h11, 8'h00, 1'b0);
        step("rb2", 4'b0100, 8'h00, 8'h00, 8'h22, 8'h00, 1'b0);
        step("rb3", 4'b0000, 8'h00, 8'h00, 8'h99, 8'h00, 1'b0);
        step("rb4", 4'b0100, 8'h00, 8'h00, 8'h33, 8'h00, 1'b0);
        check("rb_alarm2", 64'(alarm[2]),       64'd0);
        check("rb_cnt2",   64'(div_cnt[23:16]), 64'd3);

        // Clear priority: drive channel 0 into alarm, then clr with a mismatch
        for (int k = 0; k < TH; k++) step("cp_run", 4'b0001, ~m_q[0], 8'h00, 8'h00, 8'h00, 1'b0);
        check("cp_alarm0_set", 64'(alarm[0]), 64'd1);
        step("cp_clr", 4'b0001, 8'h77, 8'h00, 8'h00, 8'h00, 1'b1);
        check("cp_cnt0",    64'(div_cnt[7:0]), 64'd0);
        check("cp_alarm0",  64'(alarm[0]),     64'd0);
        check("cp_q_flop0", 64'(q_flop[7:0]),  64'h77);

        // Saturation on channel 3
        for (int k = 0; k < 258; k++) step("sat", 4'b1000, 8'h00, 8'h00, 8'h00, 8'(k + 1), 1'b0);
        check("sat_cnt3", 64'(div_cnt[31:24]), 64'd255);
        step("sat_hold", 4'b1000, 8'h00, 8'h00, 8'h00, ~m_q[3], 1'b0);
        check("sat_cnt3_hold", 64'(div_cnt[31:24]), 64'd255);

        // Mixed random traffic with occasional clears
        for (int k = 0; k < 40; k++) begin
            step("rnd", 4'($urandom), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset mid-cycle with div_cnt[0]=5 and alarm[0]=1
        step("ar_clr", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) step("ar_run", 4'b0001, ~m_q[0], 8'h00, 8'h00, 8'h00, 1'b0);
        check("ar_pre_cnt0",   64'(div_cnt[7:0]), 64'd5);
        check("ar_pre_alarm0", 64'(alarm[0]),     64'd1);
        @(negedge clk);
        en = '0;
        #2;
        rst = 1'b1;
        #1;
        check("ar_q_flop",  64'(q_flop),    64'h0);
        check("ar_q_xpar",  64'(q_xpar),    64'h0);
        check("ar_div_cnt", 64'(div_cnt),   64'h0);
        check("ar_alarm",   64'(alarm),     64'h0);
        check("ar_any",     64'(any_alarm), 64'h0);
        check("ar_irq",     64'(irq),       64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 4'b0001, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
